// File: rtl/sp_arith_pkg.sv
// Shared definitions for the sequential arithmetic blocks: FSM states,
// iteration count and parameter-legality helpers.
package sp_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    function automatic int mul_cycles(input int width, input int radix_bits);
        return (radix_bits > 0) ? (width / radix_bits) : 1;
    endfunction

    function automatic bit radix_ok(input int width, input int radix_bits);
        return (radix_bits > 0) && (radix_bits <= width) && ((width % radix_bits) == 0);
    endfunction

    function automatic bit shift_ok(input int width, input int shift);
        return (shift >= 0) && (shift < 2 * width);
    endfunction

    // The shifted product is carried at full 2*WIDTH precision, so any
    // result width up to that is representable.
    function automatic bit out_width_ok(input int width, input int out_width);
        return (out_width >= 1) && (out_width <= 2 * width);
    endfunction

endpackage

// File: rtl/sp_mul_step.sv
// One iteration of the shift-add multiplier: |a| times a RADIX_BITS-wide
// digit of |b|, placed at the digit's weight and added to the accumulator.
module sp_mul_step
    import sp_arith_pkg::*;
#(
    parameter int WIDTH      = 24,
    parameter int RADIX_BITS = 2,
    parameter int IDX_W      = 4
) (
    input  logic [2*WIDTH-1:0]    acc_i,
    input  logic [WIDTH-1:0]      a_mag_i,
    input  logic [RADIX_BITS-1:0] digit_i,
    input  logic [IDX_W-1:0]      idx_i,
    output logic [2*WIDTH-1:0]    acc_o
);

    logic [2*WIDTH-1:0] pp;
    logic [31:0]        sh_amt;

    assign pp     = (2*WIDTH)'(a_mag_i) * (2*WIDTH)'(digit_i);
    assign sh_amt = 32'(idx_i) * 32'(RADIX_BITS);
    assign acc_o  = acc_i + (pp << sh_amt);

endmodule

// File: rtl/sp_mul_seq.sv
// Iterative sign/magnitude fixed-point multiplier: RADIX_BITS multiplier bits
// per clock, result shifted right by SHIFT and truncated to OUTPUT_WIDTH.
//
// state | meaning
// IDLE  | no result yet since reset, waiting for start_in
// RUN   | accumulating partial products, one digit of |b| per clock
// DONE  | c_out/ovf_out valid and held, a new start_in is accepted
module sp_mul_seq
    import sp_arith_pkg::*;
#(
    parameter int WIDTH        = 24,
    parameter int OUTPUT_WIDTH = 48,
    parameter int SHIFT        = 18,
    parameter int RADIX_BITS   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_in,
    input  logic                    signed_in,
    input  logic [WIDTH-1:0]        a_in,
    input  logic [WIDTH-1:0]        b_in,
    output logic [OUTPUT_WIDTH-1:0] c_out,
    output logic                    ovf_out,
    output logic                    busy_out,
    output logic                    ready_out
);

    localparam int              CYCLES   = mul_cycles(WIDTH, RADIX_BITS);
    localparam int              CNT_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam int              PW       = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    if (!radix_ok(WIDTH, RADIX_BITS)) begin : g_bad_radix
        $error("sp_mul_seq: RADIX_BITS must be positive and divide WIDTH");
    end
    if (!shift_ok(WIDTH, SHIFT)) begin : g_bad_shift
        $error("sp_mul_seq: SHIFT must lie in [0, 2*WIDTH)");
    end
    if (!out_width_ok(WIDTH, OUTPUT_WIDTH)) begin : g_bad_out
        $error("sp_mul_seq: OUTPUT_WIDTH must lie in [1, 2*WIDTH]");
    end

    mul_state_e              state_q, state_d;
    logic [WIDTH-1:0]        a_mag_q, a_mag_d;
    logic [WIDTH-1:0]        b_rem_q, b_rem_d;
    logic                    neg_q, neg_d;
    logic                    smode_q, smode_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PW-1:0]           acc_q, acc_d;
    logic [OUTPUT_WIDTH-1:0] c_q, c_d;
    logic                    ovf_q, ovf_d;
    logic                    busy_q, busy_d;
    logic                    ready_q, ready_d;

    logic [WIDTH-1:0]               a_mag_in, b_mag_in;
    logic [PW-1:0]                  acc_step;
    logic [PW-1:0]                  prod;
    logic signed [PW-1:0]           shifted_s;
    logic [PW-1:0]                  shifted;
    logic [OUTPUT_WIDTH-1:0]        c_fmt;
    logic signed [OUTPUT_WIDTH-1:0] c_fmt_s;
    logic                           ovf_fmt;

    // Magnitudes fit in WIDTH bits even for -2^(WIDTH-1).
    assign a_mag_in = (signed_in && a_in[WIDTH-1]) ? (~a_in + WIDTH'(1)) : a_in;
    assign b_mag_in = (signed_in && b_in[WIDTH-1]) ? (~b_in + WIDTH'(1)) : b_in;

    sp_mul_step #(
        .WIDTH      (WIDTH),
        .RADIX_BITS (RADIX_BITS),
        .IDX_W      (CNT_W)
    ) u_step (
        .acc_i   (acc_q),
        .a_mag_i (a_mag_q),
        .digit_i (b_rem_q[RADIX_BITS-1:0]),
        .idx_i   (cnt_q),
        .acc_o   (acc_step)
    );

    // Final formatting works on the last step's sum so the result lands
    // on the same edge as the final accumulation.
    assign prod      = neg_q ? (~acc_step + PW'(1)) : acc_step;
    assign shifted_s = $signed(prod) >>> SHIFT;
    assign shifted   = smode_q ? $unsigned(shifted_s) : (prod >> SHIFT);
    assign c_fmt     = shifted[OUTPUT_WIDTH-1:0];
    assign c_fmt_s   = $signed(c_fmt);
    assign ovf_fmt   = smode_q ? (PW'(c_fmt_s) != shifted) : (PW'(c_fmt) != shifted);

    always_comb begin
        state_d = state_q;
        a_mag_d = a_mag_q;
        b_rem_d = b_rem_q;
        neg_d   = neg_q;
        smode_d = smode_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        c_d     = c_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_in) begin
                    state_d = RUN;
                    a_mag_d = a_mag_in;
                    b_rem_d = b_mag_in;
                    neg_d   = signed_in & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                    smode_d = signed_in;
                    cnt_d   = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                end
            end
            RUN: begin
                acc_d   = acc_step;
                b_rem_d = b_rem_q >> RADIX_BITS;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    c_d     = c_fmt;
                    ovf_d   = ovf_fmt;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_mag_q <= '0;
            b_rem_q <= '0;
            neg_q   <= 1'b0;
            smode_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_mag_q <= a_mag_d;
            b_rem_q <= b_rem_d;
            neg_q   <= neg_d;
            smode_q <= smode_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign c_out     = c_q;
    assign ovf_out   = ovf_q;
    assign busy_out  = busy_q;
    assign ready_out = ready_q;

endmodule
